// File: rtl/pulse_window_gen_pkg.sv
// Shared constants and state encoding for the pulse window generator.
package pulse_window_gen_pkg;

  localparam int DEFAULT_CNT_W = 32;
  localparam int MIN_PERIOD    = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

endpackage

// File: rtl/pulse_window_gen_if.sv
// Configuration/status bundle between firmware-side logic and the pulse window generator.
interface pulse_window_gen_if
  import pulse_window_gen_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
);

  logic             enable;
  logic             sync_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] condition_lower;
  logic [CNT_W-1:0] condition_upper;
  logic             pulse_out;
  logic             period_start;
  logic             update_ack;
  logic             cfg_err;
  logic             running;

  modport master (
    output enable, sync_in, period, condition_lower, condition_upper,
    input  pulse_out, period_start, update_ack, cfg_err, running
  );

  modport slave (
    input  enable, sync_in, period, condition_lower, condition_upper,
    output pulse_out, period_start, update_ack, cfg_err, running
  );

endinterface

// File: rtl/pulse_window_gen_phase_counter.sv
// Free-running phase counter: counts 0..term_i while running, with synchronous clear.
module pulse_window_gen_phase_counter
  import pulse_window_gen_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             run_i,
  input  logic [CNT_W-1:0] term_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             wrap_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign wrap_o = run_i & (cnt_q == term_i);
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || wrap_o) begin
      cnt_d = '0;
    end else if (run_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pulse_window_gen.sv
// Generates a pulse inside [lower, upper) of a programmable period; new settings
// take effect only at a period boundary (wrap or sync) so the output never glitches.
module pulse_window_gen
  import pulse_window_gen_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  pulse_window_gen_if.slave bus
);

  localparam logic [CNT_W-1:0] MinPeriod = CNT_W'(MIN_PERIOD);

  state_e           state_q;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] lower_q;
  logic [CNT_W-1:0] upper_q;
  logic             cfg_err_q;
  logic             pulse_q;
  logic             pstart_q;
  logic             ack_q;
  logic             running_q;

  logic [CNT_W-1:0] cnt;
  logic             wrap;
  logic             in_run;
  logic             reload;
  logic             cnt_clear;
  logic             new_bad_period;
  logic             new_cfg_err;
  logic             in_window;

  assign in_run         = (state_q == RUN);
  // A wrap and a sync in the same cycle collapse into one reload.
  assign reload         = bus.enable & ((state_q == LOAD) | (in_run & (wrap | bus.sync_in)));
  assign cnt_clear      = ~in_run | ~bus.enable | bus.sync_in;
  assign new_bad_period = (bus.period < MinPeriod);
  assign new_cfg_err    = new_bad_period | (bus.condition_lower >= bus.condition_upper);
  assign in_window      = (cnt >= lower_q) & (cnt < upper_q);

  pulse_window_gen_phase_counter #(
    .CNT_W (CNT_W)
  ) u_phase_counter (
    .clk     (clk),
    .reset   (reset),
    .clear_i (cnt_clear),
    .run_i   (in_run),
    .term_i  (period_q - CNT_W'(1)),
    .cnt_o   (cnt),
    .wrap_o  (wrap)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      period_q  <= '0;
      lower_q   <= '0;
      upper_q   <= '0;
      cfg_err_q <= 1'b0;
      pulse_q   <= 1'b0;
      pstart_q  <= 1'b0;
      ack_q     <= 1'b0;
      running_q <= 1'b0;
    end else begin
      pulse_q   <= in_run & ~cfg_err_q & in_window;
      pstart_q  <= in_run & (cnt == '0);
      running_q <= in_run;
      ack_q     <= reload;
      if (reload) begin
        period_q  <= bus.period;
        lower_q   <= bus.condition_lower;
        upper_q   <= bus.condition_upper;
        cfg_err_q <= new_cfg_err;
      end
      if (!bus.enable) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE:    state_q <= LOAD;
          LOAD:    state_q <= new_bad_period ? IDLE : RUN;
          RUN:     if (reload && new_bad_period) state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.pulse_out    = pulse_q;
  assign bus.period_start = pstart_q;
  assign bus.update_ack   = ack_q;
  assign bus.cfg_err      = cfg_err_q;
  assign bus.running      = running_q;

endmodule

// File: tb/tb_pulse_window_gen.sv
// Directed bench for pulse_window_gen: per-period scoreboard plus cycle-exact spot checks.
module tb_pulse_window_gen;

  localparam int CW = 32;

  typedef struct {
    string       name;
    int          len;
    logic [63:0] mask;
    logic        ack;
    logic        err;
  } winRec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  winRec_t     sbQ[$];
  bit          flushReq = 1'b0;
  bit          winOpen = 1'b0;
  int          winLen = 0;
  logic [63:0] winMask = '0;
  logic        winAck = 1'b0;
  logic        winErr = 1'b0;
  logic        prevAck = 1'b0;

  pulse_window_gen_if #(.CNT_W(CW)) bus ();

  pulse_window_gen #(.CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic sync, input int per, input int lo, input int up);
    bus.enable          = en;
    bus.sync_in         = sync;
    bus.period          = CW'(per);
    bus.condition_lower = CW'(lo);
    bus.condition_upper = CW'(up);
  endtask

  task automatic pushWin(input string name, input int len, input logic [63:0] mask, input logic ack, input logic err);
    winRec_t r;
    r.name = name;
    r.len  = len;
    r.mask = mask;
    r.ack  = ack;
    r.err  = err;
    sbQ.push_back(r);
  endtask

  task automatic waitPeriodStart(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.period_start && n < 40);
    checkOutput({name, "_ps_seen"}, 64'(bus.period_start), 64'd1);
  endtask

  task automatic stepN(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, "_pulse"},   64'(bus.pulse_out),    64'd0);
    checkOutput({name, "_pstart"},  64'(bus.period_start), 64'd0);
    checkOutput({name, "_ack"},     64'(bus.update_ack),   64'd0);
    checkOutput({name, "_cfgerr"},  64'(bus.cfg_err),      64'd0);
    checkOutput({name, "_running"}, 64'(bus.running),      64'd0);
  endtask

  // A period window runs from one period_start to the next; pulse bit k is phase k.
  always @(negedge clk) begin
    if (flushReq) begin
      winOpen  = 1'b0;
      flushReq = 1'b0;
    end else begin
      if (bus.period_start) begin
        if (winOpen) begin
          if (sbQ.size() == 0) begin
            checkOutput("sb_unexpected_window", 64'(winLen), 64'd0);
          end else begin
            winRec_t r;
            r = sbQ.pop_front();
            checkOutput({r.name, "_len"},    64'(winLen), 64'(r.len));
            checkOutput({r.name, "_mask"},   winMask,     r.mask);
            checkOutput({r.name, "_ack"},    64'(winAck), 64'(r.ack));
            checkOutput({r.name, "_cfgerr"}, 64'(winErr), 64'(r.err));
          end
        end
        winOpen = 1'b1;
        winLen  = 0;
        winMask = '0;
        winAck  = prevAck;
        winErr  = bus.cfg_err;
      end
      if (winOpen) begin
        if (bus.pulse_out && winLen < 64) winMask[winLen] = 1'b1;
        winLen++;
      end
    end
    prevAck = bus.update_ack;
  end

  initial begin
    #200000;
    failures++;
    $display("[TB] FAIL watchdog timeout reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    applyStimulus(1'b0, 1'b0, 10, 2, 5);
    stepN(2);
    checkAllZero("reset");
    reset = 1'b1;
    stepN(1);

    $display("[TB] basic window");
    pushWin("W1_basic", 10, 64'h1C, 1'b1, 1'b0);
    pushWin("W2_basic", 10, 64'h1C, 1'b1, 1'b0);
    pushWin("W3_basic", 10, 64'h1C, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 10, 2, 5);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checkOutput($sformatf("start_k%0d_ack", k),     64'(bus.update_ack),   64'(k == 2));
      checkOutput($sformatf("start_k%0d_running", k), 64'(bus.running),      64'(k >= 3));
      checkOutput($sformatf("start_k%0d_pstart", k),  64'(bus.period_start), 64'(k == 3));
      checkOutput($sformatf("start_k%0d_pulse", k),   64'(bus.pulse_out),    64'(k == 5));
    end
    waitPeriodStart("W2");
    waitPeriodStart("W3");
    stepN(2);

    $display("[TB] mid-period update");
    pushWin("W4_update", 10, 64'h1C0, 1'b1, 1'b0);
    pushWin("W5_update", 10, 64'h1C0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 10, 6, 9);
    waitPeriodStart("W4");
    waitPeriodStart("W5");

    $display("[TB] invalid lower == upper");
    pushWin("W6_badcfg", 10, 64'h0, 1'b1, 1'b1);
    pushWin("W7_badcfg", 10, 64'h0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 10, 5, 5);
    waitPeriodStart("W6");
    waitPeriodStart("W7");

    $display("[TB] clipping");
    pushWin("W8_clip", 8, 64'hC0, 1'b1, 1'b0);
    pushWin("W9_clip", 8, 64'hC0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 8, 6, 20);
    waitPeriodStart("W8");
    waitPeriodStart("W9");

    $display("[TB] sync_in");
    pushWin("W10_sync",     5,  64'h1C, 1'b1, 1'b0);
    pushWin("W11_syncwrap", 10, 64'h1C, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 10, 2, 5);
    waitPeriodStart("W10");
    stepN(3);
    bus.sync_in = 1'b1;
    @(negedge clk);
    bus.sync_in = 1'b0;
    checkOutput("sync_next_pstart", 64'(bus.period_start), 64'd0);
    checkOutput("sync_next_ack",    64'(bus.update_ack),   64'd1);
    @(negedge clk);
    checkOutput("sync_after_pstart", 64'(bus.period_start), 64'd1);
    stepN(8);
    bus.sync_in = 1'b1;
    @(negedge clk);
    bus.sync_in = 1'b0;
    checkOutput("syncwrap_c0_pstart", 64'(bus.period_start), 64'd0);
    checkOutput("syncwrap_c0_ack",    64'(bus.update_ack),   64'd1);
    @(negedge clk);
    checkOutput("syncwrap_c1_pstart", 64'(bus.period_start), 64'd1);
    @(negedge clk);
    checkOutput("syncwrap_c2_pstart", 64'(bus.period_start), 64'd0);
    @(negedge clk);

    $display("[TB] disable mid-period");
    flushReq = 1'b1;
    bus.enable = 1'b0;
    stepN(2);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("disable_d%0d_pulse", k + 2),   64'(bus.pulse_out),    64'd0);
      checkOutput($sformatf("disable_d%0d_running", k + 2), 64'(bus.running),      64'd0);
      checkOutput($sformatf("disable_d%0d_pstart", k + 2),  64'(bus.period_start), 64'd0);
      @(negedge clk);
    end

    $display("[TB] period below minimum");
    applyStimulus(1'b1, 1'b0, 1, 2, 5);
    stepN(2);
    checkOutput("per1_cfgerr",  64'(bus.cfg_err),    64'd1);
    checkOutput("per1_running", 64'(bus.running),    64'd0);
    checkOutput("per1_ack",     64'(bus.update_ack), 64'd1);
    for (int k = 3; k <= 6; k++) begin
      @(negedge clk);
      checkOutput($sformatf("per1_k%0d_running", k), 64'(bus.running),      64'd0);
      checkOutput($sformatf("per1_k%0d_pstart", k),  64'(bus.period_start), 64'd0);
      checkOutput($sformatf("per1_k%0d_pulse", k),   64'(bus.pulse_out),    64'd0);
    end
    bus.enable = 1'b0;
    stepN(3);

    $display("[TB] reset mid-period");
    applyStimulus(1'b1, 1'b0, 10, 5, 9);
    waitPeriodStart("W13");
    stepN(6);
    checkOutput("prereset_pulse",   64'(bus.pulse_out), 64'd1);
    checkOutput("prereset_running", 64'(bus.running),   64'd1);
    #1;
    reset = 1'b0;
    #1;
    checkAllZero("async_reset");
    flushReq = 1'b1;
    stepN(2);
    checkAllZero("reset_hold");
    pushWin("W14_restart", 10, 64'h1E0, 1'b1, 1'b0);
    pushWin("W15_restart", 10, 64'h1E0, 1'b1, 1'b0);
    reset = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checkOutput($sformatf("restart_k%0d_ack", k),     64'(bus.update_ack),   64'(k == 2));
      checkOutput($sformatf("restart_k%0d_running", k), 64'(bus.running),      64'(k == 3));
      checkOutput($sformatf("restart_k%0d_pstart", k),  64'(bus.period_start), 64'(k == 3));
    end
    waitPeriodStart("W15");
    waitPeriodStart("W16");
    @(negedge clk);
    checkOutput("sb_drain", 64'(sbQ.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
